// File: rtl/multicycle_ctrl_fsm.sv
// ============================================================================
// Module   : multicycle_ctrl_fsm
// Purpose  : Multicycle control unit for the RV64 datapath. Decodes the
//            instruction register and drives every datapath control flag,
//            waits on variable-latency instruction/data memory with a bounded
//            timeout, evaluates beq/bne, and parks in a sticky TRAP state on
//            illegal instructions or memory timeouts.
// Options  : `define CTRL_EXT_BRANCH_EN adds blt/bge (funct3 100/101) using
//            alu_less; without it those encodings trap as illegal.
// Ports    : clk, reset (async, active high)
//            instruction[31:0], alu_zero, alu_less, imem_ready, dmem_ready
//            pc_write, pc_source, alu_src_a, alu_src_b[1:0], alu_op[3:0],
//            load_aout, load_reg_a, load_reg_b, reg_write, mem_to_reg,
//            imem_req, ir_write, dmem_req, dmem_we, load_mdr,
//            trap, trap_cause[1:0] (01 illegal, 10 imem t/o, 11 dmem t/o)
// Revision : 2.0 - async reset, memory handshakes, branches, trap state
// ============================================================================
`default_nettype none

module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  input  logic        alu_less,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        pc_source,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        load_aout,
  output logic        load_reg_a,
  output logic        load_reg_b,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        imem_req,
  output logic        ir_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        load_mdr,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  // Datapath select / ALU codes (operations package encoding)
  localparam logic       PC_ALU_OUT   = 1'b0;
  localparam logic       PC_ALU_REG   = 1'b1;
  localparam logic       ALA_PC       = 1'b0;
  localparam logic       ALA_REG_A    = 1'b1;
  localparam logic [1:0] ALB_REG_B    = 2'd0;
  localparam logic [1:0] ALB_CONST4   = 2'd1;
  localparam logic [1:0] ALB_IMM      = 2'd2;
  localparam logic [1:0] ALB_IMM2     = 2'd3;
  localparam logic       FW_ALU_OUT   = 1'b0;
  localparam logic       FW_MDR       = 1'b1;
  localparam logic [3:0] ALU_SUM      = 4'd0;
  localparam logic [3:0] ALU_SUB      = 4'd1;
  localparam logic [3:0] ALU_AND      = 4'd2;
  localparam logic [3:0] ALU_LESS     = 4'd4;
  localparam logic [3:0] ALU_SLL      = 4'd5;
  localparam logic [3:0] ALU_SRL      = 4'd6;
  localparam logic [3:0] ALU_SRA      = 4'd7;
  localparam logic [3:0] ALU_LOAD     = 4'd8;

  // Opcodes. SD and TYPE_S share one encoding.
  localparam logic [6:0] OP_LD        = 7'b0000011;
  localparam logic [6:0] OP_SD        = 7'b0100011;
  localparam logic [6:0] OP_IMM       = 7'b0010011;
  localparam logic [6:0] OP_R         = 7'b0110011;
  localparam logic [6:0] OP_U         = 7'b0110111;
  localparam logic [6:0] OP_SB        = 7'b1100011;
  localparam logic [6:0] F7_SRAI      = 7'b0100000;

  localparam logic [1:0] CAUSE_ILL    = 2'b01;
  localparam logic [1:0] CAUSE_IMEM   = 2'b10;
  localparam logic [1:0] CAUSE_DMEM   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_LD, S_MEM_SD, S_WB_LD,
    S_EXEC_R, S_EXEC_I, S_EXEC_U, S_ALU_WB, S_BRANCH, S_TRAP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic [1:0]       cause_next;
  logic             timed_out;

  wire [6:0] opcode = instruction[6:0];
  wire [2:0] funct3 = instruction[14:12];
  wire [6:0] funct7 = instruction[31:25];

  // Register fields are consumed by the datapath, not by control.
`ifdef CTRL_EXT_BRANCH_EN
  wire unused_bits = ^{instruction[24:15], instruction[11:7]};
`else
  wire unused_bits = ^{instruction[24:15], instruction[11:7], alu_less};
`endif

  assign timed_out = (wait_cnt == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      trap_cause <= 2'b00;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_cnt_next;
      trap_cause <= cause_next;
    end
  end

  always_comb begin
    state_next    = state;
    cause_next    = trap_cause;
    wait_cnt_next = '0;  // any exit from a wait state clears the counter
    pc_write      = 1'b0;
    pc_source     = PC_ALU_OUT;
    alu_src_a     = ALA_PC;
    alu_src_b     = ALB_REG_B;
    alu_op        = ALU_SUM;
    load_aout     = 1'b0;
    load_reg_a    = 1'b0;
    load_reg_b    = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = FW_ALU_OUT;
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    load_mdr      = 1'b0;
    trap          = 1'b0;

    case (state)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        imem_req  = 1'b1;
        alu_src_a = ALA_PC;
        alu_src_b = ALB_CONST4;
        if (imem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          pc_source  = PC_ALU_OUT;
          state_next = S_DECODE;
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = CAUSE_IMEM;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
        end
      end

      S_DECODE: begin
        load_reg_a = 1'b1;
        load_reg_b = 1'b1;
        load_aout  = 1'b1;
        alu_src_a  = ALA_PC;
        alu_src_b  = ALB_IMM2;
        case (opcode)
          OP_LD, OP_SD: state_next = S_MEM_ADDR;
          OP_IMM:       state_next = S_EXEC_I;
          OP_R:         state_next = S_EXEC_R;
          OP_U:         state_next = S_EXEC_U;
          OP_SB:        state_next = S_BRANCH;
          default: begin
            state_next = S_TRAP;
            cause_next = CAUSE_ILL;
          end
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a  = ALA_REG_A;
        alu_src_b  = ALB_IMM;
        load_aout  = 1'b1;
        state_next = (opcode == OP_LD) ? S_MEM_LD : S_MEM_SD;
      end

      S_MEM_LD, S_MEM_SD: begin
        dmem_req = 1'b1;
        dmem_we  = (state == S_MEM_SD);
        if (dmem_ready) begin
          load_mdr   = (state == S_MEM_LD);
          state_next = (state == S_MEM_LD) ? S_WB_LD : S_FETCH;
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = CAUSE_DMEM;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
        end
      end

      S_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = FW_MDR;
        state_next = S_FETCH;
      end

      S_EXEC_R: begin
        alu_src_a  = ALA_REG_A;
        alu_src_b  = ALB_REG_B;
        load_aout  = 1'b1;
        state_next = S_ALU_WB;
        case (funct3)
          3'b000:  alu_op = funct7[5] ? ALU_SUB : ALU_SUM;
          3'b001:  alu_op = ALU_SLL;
          3'b111:  alu_op = ALU_AND;
          default: begin
            state_next = S_TRAP;
            cause_next = CAUSE_ILL;
          end
        endcase
      end

      S_EXEC_I: begin
        alu_src_a  = ALA_REG_A;
        alu_src_b  = ALB_IMM;
        load_aout  = 1'b1;
        state_next = S_ALU_WB;
        case (funct3)
          3'b000:  alu_op = ALU_SUM;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_LESS;
          3'b101:  alu_op = (funct7 == F7_SRAI) ? ALU_SRA : ALU_SRL;
          default: begin
            state_next = S_TRAP;
            cause_next = CAUSE_ILL;
          end
        endcase
      end

      S_EXEC_U: begin
        alu_src_a  = ALA_REG_A;
        alu_src_b  = ALB_IMM;
        alu_op     = ALU_LOAD;
        load_aout  = 1'b1;
        state_next = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = FW_ALU_OUT;
        state_next = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a  = ALA_REG_A;
        alu_src_b  = ALB_REG_B;
        alu_op     = ALU_SUB;
        pc_source  = PC_ALU_REG;
        state_next = S_FETCH;
        case (funct3)
          3'b000:  pc_write = alu_zero;
          3'b001:  pc_write = ~alu_zero;
`ifdef CTRL_EXT_BRANCH_EN
          3'b100:  pc_write = alu_less;
          3'b101:  pc_write = ~alu_less;
`endif
          default: begin
            state_next = S_TRAP;
            cause_next = CAUSE_ILL;
          end
        endcase
      end

      S_TRAP: trap = 1'b1;  // only reset leaves this state

      default: state_next = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none

module tb_multicycle_ctrl_fsm;

  localparam int MEM_TIMEOUT = 15;
`ifdef CTRL_EXT_BRANCH_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  localparam logic       PC_ALU_REG = 1'b1;
  localparam logic       ALA_REG_A  = 1'b1;
  localparam logic [1:0] ALB_REG_B  = 2'd0;
  localparam logic [1:0] ALB_CONST4 = 2'd1;
  localparam logic [1:0] ALB_IMM    = 2'd2;
  localparam logic [1:0] ALB_IMM2   = 2'd3;
  localparam logic [3:0] ALU_SUM    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_LESS   = 4'd4;
  localparam logic [3:0] ALU_SLL    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_LOAD   = 4'd8;
  localparam logic [6:0] OP_LD      = 7'b0000011;
  localparam logic [6:0] OP_SD      = 7'b0100011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_U       = 7'b0110111;
  localparam logic [6:0] OP_SB      = 7'b1100011;

  typedef struct packed {
    logic       pcw;  logic pcs;  logic a;  logic [1:0] b;  logic [3:0] op;
    logic       laout; logic lra; logic lrb; logic rw; logic m2r;
    logic       ireq; logic irw;  logic dreq; logic dwe; logic mdr;
    logic       trap; logic [1:0] cause;
  } outs_t;

  typedef struct {
    logic [31:0] ins;
    logic        ir, dr, z, lt;
    outs_t       exp;
    string       tag;
  } cyc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic        alu_zero = 1'b0, alu_less = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic        pc_write, pc_source, alu_src_a, load_aout, load_reg_a, load_reg_b;
  logic        reg_write, mem_to_reg, imem_req, ir_write, dmem_req, dmem_we, load_mdr, trap;
  logic [1:0]  alu_src_b, trap_cause;
  logic [3:0]  alu_op;
  outs_t       act;

  int   checks = 0;
  int   errors = 0;
  cyc_t q[$];
  bit   m_trapped;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .alu_zero(alu_zero), .alu_less(alu_less),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .load_aout(load_aout),
    .load_reg_a(load_reg_a), .load_reg_b(load_reg_b), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .imem_req(imem_req), .ir_write(ir_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .load_mdr(load_mdr),
    .trap(trap), .trap_cause(trap_cause)
  );

  assign act = {pc_write, pc_source, alu_src_a, alu_src_b, alu_op, load_aout,
                load_reg_a, load_reg_b, reg_write, mem_to_reg, imem_req, ir_write,
                dmem_req, dmem_we, load_mdr, trap, trap_cause};

  // ---------------- reference model: instruction -> expected cycle list ------
  function automatic cyc_t blank(input logic [31:0] ins, input string tag);
    cyc_t c;
    c.ins = ins;
    c.ir  = 1'($urandom);
    c.dr  = 1'($urandom);
    c.z   = 1'($urandom);
    c.lt  = 1'($urandom);
    c.exp = '0;
    c.exp.op = ALU_SUM;
    c.tag = tag;
    return c;
  endfunction

  task automatic model_trap(input int n, input logic [1:0] cause);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      c = blank($urandom, "trap_hold");
      c.exp.trap  = 1'b1;
      c.exp.cause = cause;
      q.push_back(c);
    end
  endtask

  // Memory wait phase: cycle k has k earlier unready cycles behind it.
  // Returns 1 when the phase ends in a timeout.
  task automatic model_wait(input logic [31:0] ins, input int w, input bit is_imem,
                            input bit is_st, output bit to);
    cyc_t c;
    to = 1'b0;
    for (int k = 0; ; k++) begin
      c = blank(ins, is_imem ? "fetch" : (is_st ? "mem_sd" : "mem_ld"));
      if (is_imem) begin
        c.exp.ireq = 1'b1;
        c.exp.b    = ALB_CONST4;
      end else begin
        c.exp.dreq = 1'b1;
        c.exp.dwe  = is_st;
      end
      if (k == w) begin
        if (is_imem) begin c.ir = 1'b1; c.exp.irw = 1'b1; c.exp.pcw = 1'b1; end
        else begin c.dr = 1'b1; c.exp.mdr = !is_st; end
        q.push_back(c);
        break;
      end
      if (is_imem) c.ir = 1'b0; else c.dr = 1'b0;
      q.push_back(c);
      if (k == MEM_TIMEOUT) begin to = 1'b1; break; end
    end
  endtask

  task automatic model_instr(input logic [31:0] ins, input int iw, input int dw,
                             input logic z, input logic lt, output logic [1:0] cause);
    cyc_t c;
    bit to;
    logic [2:0] f3;
    f3 = ins[14:12];
    cause = 2'b00;
    model_wait(ins, iw, 1'b1, 1'b0, to);
    if (to) begin cause = 2'b10; m_trapped = 1'b1; return; end
    c = blank(ins, "decode");
    c.exp.lra = 1'b1; c.exp.lrb = 1'b1; c.exp.laout = 1'b1; c.exp.b = ALB_IMM2;
    q.push_back(c);
    case (ins[6:0])
      OP_LD, OP_SD: begin
        c = blank(ins, "mem_addr");
        c.exp.a = ALA_REG_A; c.exp.b = ALB_IMM; c.exp.laout = 1'b1;
        q.push_back(c);
        model_wait(ins, dw, 1'b0, ins[6:0] == OP_SD, to);
        if (to) begin cause = 2'b11; m_trapped = 1'b1; return; end
        if (ins[6:0] == OP_LD) begin
          c = blank(ins, "wb_ld");
          c.exp.rw = 1'b1; c.exp.m2r = 1'b1;
          q.push_back(c);
        end
      end
      OP_R, OP_IMM, OP_U: begin
        c = blank(ins, "exec");
        c.exp.a = ALA_REG_A; c.exp.laout = 1'b1;
        c.exp.b = (ins[6:0] == OP_R) ? ALB_REG_B : ALB_IMM;
        if (ins[6:0] == OP_U) c.exp.op = ALU_LOAD;
        else if (ins[6:0] == OP_R) begin
          if (f3 == 3'b000) c.exp.op = ins[30] ? ALU_SUB : ALU_SUM;
          else if (f3 == 3'b001) c.exp.op = ALU_SLL;
          else if (f3 == 3'b111) c.exp.op = ALU_AND;
          else cause = 2'b01;
        end else begin
          if (f3 == 3'b000) c.exp.op = ALU_SUM;
          else if (f3 == 3'b001) c.exp.op = ALU_SLL;
          else if (f3 == 3'b010) c.exp.op = ALU_LESS;
          else if (f3 == 3'b101) c.exp.op = (ins[31:25] == 7'b0100000) ? ALU_SRA : ALU_SRL;
          else cause = 2'b01;
        end
        q.push_back(c);
        if (cause != 2'b00) begin m_trapped = 1'b1; return; end
        c = blank(ins, "alu_wb");
        c.exp.rw = 1'b1;
        q.push_back(c);
      end
      OP_SB: begin
        c = blank(ins, "branch");
        c.z = z; c.lt = lt;
        c.exp.a = ALA_REG_A; c.exp.b = ALB_REG_B; c.exp.op = ALU_SUB; c.exp.pcs = PC_ALU_REG;
        if (f3 == 3'b000) c.exp.pcw = z;
        else if (f3 == 3'b001) c.exp.pcw = !z;
        else if (EXT && f3 == 3'b100) c.exp.pcw = lt;
        else if (EXT && f3 == 3'b101) c.exp.pcw = !lt;
        else cause = 2'b01;
        q.push_back(c);
        if (cause != 2'b00) m_trapped = 1'b1;
      end
      default: begin cause = 2'b01; m_trapped = 1'b1; end
    endcase
  endtask

  function automatic logic [31:0] rand_instr(input int kind);
    logic [31:0] r;
    logic        hi;
    int          s;
    r  = $urandom;
    hi = r[30];
    s  = 0;
    case (kind)
      0: begin
        s = $urandom_range(0, 2);
        r[14:12] = (s == 0) ? 3'b000 : (s == 1) ? 3'b001 : 3'b111;
        r[31:25] = (s == 0 && hi) ? 7'b0100000 : 7'b0000000;
        r[6:0] = OP_R;
      end
      1: begin
        s = $urandom_range(0, 3);
        r[14:12] = (s == 0) ? 3'b000 : (s == 1) ? 3'b001 : (s == 2) ? 3'b010 : 3'b101;
        if (s == 3) r[31:25] = hi ? 7'b0100000 : 7'b0000000;
        r[6:0] = OP_IMM;
      end
      2: r[6:0] = OP_U;
      3: r[6:0] = OP_LD;
      4: r[6:0] = OP_SD;
      default: begin
        s = EXT ? $urandom_range(0, 3) : $urandom_range(0, 1);
        r[14:12] = (s == 0) ? 3'b000 : (s == 1) ? 3'b001 : (s == 2) ? 3'b100 : 3'b101;
        r[6:0] = OP_SB;
      end
    endcase
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    imem_ready = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0; alu_less = 1'b0;
    instruction = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    m_trapped = 1'b0;
    q.push_back(blank($urandom, "idle"));
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    outs_t    zero_o;
    cyc_t     c;
    logic [1:0] cause;
    zero_o = '0;
    zero_o.op = ALU_SUM;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      c = blank(32'h13, "fetch_wait");
      c.ir = 1'b0; c.exp.ireq = 1'b1; c.exp.b = ALB_CONST4;
      q.push_back(c);
    end
    foreach (q[i]) begin
      instruction = q[i].ins; imem_ready = q[i].ir; dmem_ready = q[i].dr;
      alu_zero = q[i].z; alu_less = q[i].lt;
      @(negedge clk);
      checks++;
      if (act !== q[i].exp) begin
        errors++;
        $display("FAIL reset_pre.%s cyc %0d: got %h want %h", q[i].tag, i, act, q[i].exp);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (act !== zero_o) begin
      errors++;
      $display("FAIL reset_async_fetch: got %h want %h", act, zero_o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    m_trapped = 1'b0;
    q.push_back(blank($urandom, "idle_after_reset"));
    model_instr(32'h13, 1000, 0, 1'b0, 1'b0, cause);
    model_trap(3, cause);
    foreach (q[i]) begin
      instruction = q[i].ins; imem_ready = q[i].ir; dmem_ready = q[i].dr;
      alu_zero = q[i].z; alu_less = q[i].lt;
      @(negedge clk);
      checks++;
      if (act !== q[i].exp) begin
        errors++;
        $display("FAIL reset_post.%s cyc %0d: got %h want %h", q[i].tag, i, act, q[i].exp);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (act !== zero_o) begin
      errors++;
      $display("FAIL reset_async_trap: got %h want %h", act, zero_o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_alu_ops();
    logic [1:0] cause;
    do_reset();
    model_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, cause);          // add x3,x1,x2
    model_instr(32'h402081B3, 0, 0, 1'b0, 1'b0, cause);          // sub
    model_instr(32'h4050D093, 1, 0, 1'b0, 1'b0, cause);          // srai
    model_instr(32'h0050D093, 0, 0, 1'b0, 1'b0, cause);          // srli
    model_instr(32'h0000A093, 2, 0, 1'b0, 1'b0, cause);          // slti
    model_instr(32'h123450B7, 0, 0, 1'b0, 1'b0, cause);          // lui
    model_instr(32'h0020F1B3, 0, 0, 1'b0, 1'b0, cause);          // and
    foreach (q[i]) begin
      instruction = q[i].ins; imem_ready = q[i].ir; dmem_ready = q[i].dr;
      alu_zero = q[i].z; alu_less = q[i].lt;
      @(negedge clk);
      checks++;
      if (act !== q[i].exp) begin
        errors++;
        $display("FAIL alu_ops.%s cyc %0d: got %h want %h", q[i].tag, i, act, q[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_store();
    logic [1:0] cause;
    do_reset();
    model_instr(32'h0080B183, 0, 5, 1'b0, 1'b0, cause);          // ld, 5 wait cycles
    model_instr(32'h0030B423, 0, 0, 1'b0, 1'b0, cause);          // sd, zero wait
    model_instr(32'h0030B423, 2, 3, 1'b0, 1'b0, cause);          // sd, waits
    model_instr(32'h0080B183, 0, 0, 1'b0, 1'b0, cause);          // ld, zero wait
    foreach (q[i]) begin
      instruction = q[i].ins; imem_ready = q[i].ir; dmem_ready = q[i].dr;
      alu_zero = q[i].z; alu_less = q[i].lt;
      @(negedge clk);
      checks++;
      if (act !== q[i].exp) begin
        errors++;
        $display("FAIL load_store.%s cyc %0d: got %h want %h", q[i].tag, i, act, q[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [1:0] cause;
    do_reset();
    model_instr(32'h00208463, 0, 0, 1'b1, 1'b0, cause);          // beq taken
    model_instr(32'h00208463, 0, 0, 1'b0, 1'b1, cause);          // beq not taken
    model_instr(32'h00209463, 0, 0, 1'b1, 1'b1, cause);          // bne not taken
    model_instr(32'h00209463, 1, 0, 1'b0, 1'b0, cause);          // bne taken
    model_instr(32'h0020C463, 0, 0, 1'b0, 1'b1, cause);          // blt (traps unless ext)
    if (!m_trapped) begin
      model_instr(32'h0020D463, 0, 0, 1'b0, 1'b1, cause);        // bge not taken
      model_instr(32'h0020D463, 0, 0, 1'b1, 1'b0, cause);        // bge taken
    end else begin
      model_trap(5, cause);
    end
    foreach (q[i]) begin
      instruction = q[i].ins; imem_ready = q[i].ir; dmem_ready = q[i].dr;
      alu_zero = q[i].z; alu_less = q[i].lt;
      @(negedge clk);
      checks++;
      if (act !== q[i].exp) begin
        errors++;
        $display("FAIL branch.%s cyc %0d: got %h want %h", q[i].tag, i, act, q[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    logic [1:0] cause;
    do_reset();
    model_instr(32'h002081B3, MEM_TIMEOUT, 0, 1'b0, 1'b0, cause);     // ready at the limit wins
    model_instr(32'h0080B183, 10, MEM_TIMEOUT, 1'b0, 1'b0, cause);    // counter clears between phases
    model_instr(32'h0030B423, 0, 1000, 1'b0, 1'b0, cause);            // dmem timeout
    model_trap(4, cause);
    do_reset_keep_queue_check("timeout_a");
    do_reset();
    model_instr(32'h0080B183, MEM_TIMEOUT - 1, 1000, 1'b0, 1'b0, cause);
    model_trap(3, cause);
    foreach (q[i]) begin
      instruction = q[i].ins; imem_ready = q[i].ir; dmem_ready = q[i].dr;
      alu_zero = q[i].z; alu_less = q[i].lt;
      @(negedge clk);
      checks++;
      if (act !== q[i].exp) begin
        errors++;
        $display("FAIL timeout_b.%s cyc %0d: got %h want %h", q[i].tag, i, act, q[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  // Plays out the queue built so far for the first half of test_timeout.
  task automatic do_reset_keep_queue_check(input string name);
    foreach (q[i]) begin
      instruction = q[i].ins; imem_ready = q[i].ir; dmem_ready = q[i].dr;
      alu_zero = q[i].z; alu_less = q[i].lt;
      @(negedge clk);
      checks++;
      if (act !== q[i].exp) begin
        errors++;
        $display("FAIL %s.%s cyc %0d: got %h want %h", name, q[i].tag, i, act, q[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [1:0]  cause;
    logic [31:0] bad [4];
    bad[0] = 32'h0000007F;   // unknown opcode
    bad[1] = 32'h0020A1B3;   // R-type funct3 010
    bad[2] = 32'h0000B093;   // I-type funct3 011
    bad[3] = 32'h0020E463;   // branch funct3 110
    for (int t = 0; t < 4; t++) begin
      do_reset();
      model_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, cause);
      model_instr(bad[t], $urandom_range(0, 2), 0, 1'b0, 1'b0, cause);
      model_trap(20, cause);
      q.push_back(blank($urandom, "trap_cause_check"));
      q[q.size()-1].exp.trap  = 1'b1;
      q[q.size()-1].exp.cause = 2'b01;
      foreach (q[i]) begin
        instruction = q[i].ins; imem_ready = q[i].ir; dmem_ready = q[i].dr;
        alu_zero = q[i].z; alu_less = q[i].lt;
        @(negedge clk);
        checks++;
        if (act !== q[i].exp) begin
          errors++;
          $display("FAIL illegal%0d.%s cyc %0d: got %h want %h", t, q[i].tag, i, act, q[i].exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] cause;
    int         iw, dw;
    do_reset();
    for (int n = 0; n < 60 && !m_trapped; n++) begin
      iw = ($urandom_range(0, 7) == 0) ? MEM_TIMEOUT : $urandom_range(0, 3);
      dw = ($urandom_range(0, 7) == 0) ? MEM_TIMEOUT : $urandom_range(0, 3);
      model_instr(rand_instr($urandom_range(0, 5)), iw, dw,
                  1'($urandom), 1'($urandom), cause);
    end
    foreach (q[i]) begin
      instruction = q[i].ins; imem_ready = q[i].ir; dmem_ready = q[i].dr;
      alu_zero = q[i].z; alu_less = q[i].lt;
      @(negedge clk);
      checks++;
      if (act !== q[i].exp) begin
        errors++;
        $display("FAIL back_to_back.%s cyc %0d: got %h want %h", q[i].tag, i, act, q[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_store();
    test_branch();
    test_timeout();
    test_illegal();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Second-generation multicycle control unit for the RV64 datapath (processing). It decodes the instruction register and drives every datapath control flag. Over the first generation it adds:
- asynchronous reset;
- variable-latency instruction and data memory through ready handshakes, with a bounded wait timeout;
- evaluated conditional branches (beq/bne);
- a sticky trap state for illegal opcodes and memory timeouts.

Parameters:
MEM_TIMEOUT, 15, maximum consecutive wait cycles in a memory state before trapping (1..2^CNT_W-1)
CNT_W, 4, width of the wait counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
instruction  input  32  current IR contents (opcode [6:0], funct3 [14:12], funct7 [31:25])
alu_zero  input  1  ALU result == 0, valid combinationally in the BRANCH state
alu_less  input  1  ALU signed less-than flag (used only with CTRL_EXT_BRANCH_EN)
imem_ready  input  1  instruction memory data valid this cycle
dmem_ready  input  1  data memory read data valid / write accepted this cycle
pc_write  output  1  PC load enable
pc_source  output  1  operations::_PC_ALU_OUT or _PC_ALU_REG
alu_src_a  output  1  operations::_ALA_PC or _ALA_REG_A
alu_src_b  output  2  operations::_ALB_* select
alu_op  output  4  operations:: ALU operation code
load_aout  output  1  ALU output register load
load_reg_a, load_reg_b  output  1 each  A/B register loads
reg_write  output  1  regfile write enable
mem_to_reg  output  1  writeback select (1 = MDR)
imem_req  output  1  instruction fetch request
ir_write  output  1  IR load
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (valid with dmem_req)
load_mdr  output  1  MDR load
trap  output  1  sticky: core halted
trap_cause  output  2  01 illegal instr, 10 imem timeout, 11 dmem timeout, 00 none

Behaviour:
Reset and defaults
- Reset (asynchronous): state=IDLE, wait counter=0, trap=0, trap_cause=00.
- All outputs are combinational from state/inputs. Default every cycle: all flags 0, alu_op=SUM.
- Reset asserted mid-wait or in TRAP aborts immediately. There is no other exit from TRAP.

State machine
- IDLE: no flags -> FETCH.
- FETCH: imem_req=1, alu_src_a=_ALA_PC, alu_src_b=_ALB_CONST4, alu_op=SUM.
  - On imem_ready: ir_write=1, pc_write=1, pc_source=_PC_ALU_OUT -> DECODE.
  - Otherwise remain.
- DECODE: load_reg_a=load_reg_b=load_aout=1, alu_src_a=_ALA_PC, alu_src_b=_ALB_IMM2, alu_op=SUM. Dispatch on opcode:
  - LD/SD/TYPE_S -> MEM_ADDR
  - IMM_ARITH -> EXEC_I
  - TYPE_R -> EXEC_R
  - TYPE_U -> EXEC_U
  - TYPE_SB -> BRANCH
  - any other -> TRAP, cause 01
- MEM_ADDR: alu_src_a=_ALA_REG_A, alu_src_b=_ALB_IMM, SUM, load_aout=1 -> MEM_LD (LD) or MEM_SD (SD/TYPE_S).
- MEM_LD: dmem_req=1. On dmem_ready: load_mdr=1 -> WB_LD.
- MEM_SD: dmem_req=dmem_we=1. On dmem_ready -> FETCH.
- WB_LD: reg_write=1, mem_to_reg=1 -> FETCH.
- EXEC_R: operands _ALA_REG_A/_ALB_REG_B, load_aout=1. alu_op by funct3:
  - 000: SUM if funct7[5]=0, else SUB
  - 001: SHIFT_LEFT
  - 111: AND
  - other -> TRAP, cause 01
- EXEC_I: operands REG_A/IMM, load_aout=1. alu_op by funct3:
  - 000: SUM
  - 001: SHIFT_LEFT
  - 010: LESS
  - 101: SHIFT_RIGHT_A if funct7==F7_SRAI, else SHIFT_RIGHT
  - other -> TRAP, cause 01
- EXEC_U: operands REG_A/IMM, alu_op=LOAD, load_aout=1.
- EXEC_R, EXEC_I and EXEC_U all -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=_FW_ALU_OUT -> FETCH.
- BRANCH: operands REG_A/REG_B, alu_op=SUB, pc_source=_PC_ALU_REG.
  - pc_write = (funct3==000 & alu_zero) | (funct3==001 & ~alu_zero).
  - Other funct3 -> TRAP, cause 01.
  - Otherwise -> FETCH.
- TRAP: all flags 0, trap=1, trap_cause held.

Wait counter
- Counts cycles spent in FETCH, MEM_LD or MEM_SD without the matching ready.
- Cleared on any state change and on ready.
- If the counter equals MEM_TIMEOUT and ready is still low: -> TRAP, cause 10 (FETCH) or 11 (MEM_LD/MEM_SD).
- Ready on the same cycle the counter reaches MEM_TIMEOUT wins: normal transition, no trap.

Latency
- Minimum per instruction with zero-wait memory: R/I/U = 4 cycles (FETCH, DECODE, EXEC, ALU_WB); LD = 5; SD = 4; branch = 3.

Optional Feature:
CTRL_EXT_BRANCH_EN:
- Defined: BRANCH also evaluates funct3 100 (blt: taken if alu_less) and 101 (bge: taken if ~alu_less). alu_op stays SUB.
- Undefined: funct3 100/101 trap with cause 01, and alu_less is ignored.

Test Plan:
1. Reset mid-FETCH with imem_ready=0 for 3 cycles -> all outputs 0 and alu_op=SUM immediately; after release, IDLE then FETCH with imem_req=1 and wait counter at 0.
2. add x3,x1,x2 (0x002081B3) with zero-wait memory -> ir_write/pc_write in cycle 1, EXEC_R with alu_op=SUM, reg_write=1 in cycle 4, back in FETCH in cycle 5.
3. ld with dmem_ready delayed 5 cycles -> dmem_req held 6 cycles, load_mdr=1 only on the ready cycle, WB_LD has reg_write=1 and mem_to_reg=1.
4. beq: alu_zero=1 -> pc_write=1 with pc_source=_PC_ALU_REG. Repeat with alu_zero=0 -> pc_write=0. bne gives the inverse.
5. imem_ready held low -> trap=1 and trap_cause=10 exactly after MEM_TIMEOUT=15 wait cycles. Same scenario with ready arriving on cycle 15 -> no trap.
6. opcode 0x7F in DECODE -> TRAP, cause 01, all flags 0 for the next 20 cycles; only reset clears it. With CTRL_EXT_BRANCH_EN, blt with alu_less=1 -> pc_write=1.
